// File: rtl/pixel_out_serializer_if.sv
// Pixel-in / byte-out bus of pixel_out_serializer; master is the serializer.
// parity_o exists only when OUT_PARITY_EN is defined.
interface pixel_out_serializer_if #(
    parameter int MAX_PIXEL_BITS = 24
);
    logic                      byte_mode_i;
    logic                      px_rdy_i;
    logic [MAX_PIXEL_BITS-1:0] in_pixel_i;
    logic [7:0]                byte_o;
    logic                      byte_valid_o;
    logic                      byte_ack_i;
    logic                      fifo_full_o;
    logic                      overflow_o;
`ifdef OUT_PARITY_EN
    logic                      parity_o;
`endif

    modport master (
        input  byte_mode_i,
        input  px_rdy_i,
        input  in_pixel_i,
        input  byte_ack_i,
        output byte_o,
        output byte_valid_o,
        output fifo_full_o,
`ifdef OUT_PARITY_EN
        output parity_o,
`endif
        output overflow_o
    );

    modport slave (
        output byte_mode_i,
        output px_rdy_i,
        output in_pixel_i,
        output byte_ack_i,
        input  byte_o,
        input  byte_valid_o,
        input  fifo_full_o,
`ifdef OUT_PARITY_EN
        input  parity_o,
`endif
        input  overflow_o
    );
endinterface

// File: rtl/pixel_out_serializer.sv
// Buffers px_rdy-qualified pixels in a small FIFO and emits them MSB-first as bytes
// over a valid/ack handshake. Optional feature macro: OUT_PARITY_EN (adds parity_o).
module pixel_out_serializer #(
    parameter int MAX_PIXEL_BITS = 24,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                  clk_i,
    input  logic                  nreset_i,
    pixel_out_serializer_if.master bus
);
    localparam int              PW       = $clog2(FIFO_DEPTH);
    localparam int              SW       = MAX_PIXEL_BITS - 8;
    localparam logic [PW:0]     DEPTH_C  = FIFO_DEPTH[PW:0];
    localparam logic [PW:0]     CNT_ONE  = 1;
    localparam logic [PW-1:0]   PTR_ONE  = 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                    state_q;
    logic [MAX_PIXEL_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [PW:0]               count_q, count_d;
    logic [SW-1:0]             shift_q;
    logic [1:0]                bytes_left_q;
    logic [7:0]                byte_q;
    logic                      valid_q, full_q, ovf_q;
`ifdef OUT_PARITY_EN
    logic                      parity_q;
`endif

    logic                      push, pop;
    logic [MAX_PIXEL_BITS-1:0] pop_pixel;
    logic [7:0]                first_byte;

    // Fullness is judged on the pre-edge count, so a same-cycle pop never makes room.
    always_comb begin
        push       = bus.px_rdy_i && (count_q != DEPTH_C);
        pop        = 1'b0;
        pop_pixel  = mem[rd_ptr_q];
        first_byte = bus.byte_mode_i ? pop_pixel[7:0] : pop_pixel[MAX_PIXEL_BITS-1 -: 8];
        if (count_q != '0) begin
            if (state_q == IDLE) begin
                pop = 1'b1;
            end else if (bus.byte_ack_i && (bytes_left_q == 2'd1)) begin
                pop = 1'b1;
            end
        end
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.in_pixel_i;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            shift_q      <= '0;
            bytes_left_q <= '0;
            byte_q       <= '0;
            valid_q      <= 1'b0;
            full_q       <= 1'b0;
            ovf_q        <= 1'b0;
`ifdef OUT_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (bus.px_rdy_i && !push) begin
                ovf_q <= 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end

            // A pop in SEND only happens on the last byte's ack: back-to-back, no bubble.
            if (pop) begin
                shift_q      <= pop_pixel[SW-1:0];
                byte_q       <= first_byte;
                bytes_left_q <= bus.byte_mode_i ? 2'd1 : 2'd3;
                valid_q      <= 1'b1;
                state_q      <= SEND;
`ifdef OUT_PARITY_EN
                parity_q     <= ^first_byte;
`endif
            end else if ((state_q == SEND) && bus.byte_ack_i) begin
                if (bytes_left_q != 2'd1) begin
                    byte_q       <= shift_q[SW-1 -: 8];
                    shift_q      <= {shift_q[SW-9:0], 8'h00};
                    bytes_left_q <= bytes_left_q - 2'd1;
`ifdef OUT_PARITY_EN
                    parity_q     <= ^shift_q[SW-1 -: 8];
`endif
                end else begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            end
        end
    end

    assign bus.byte_o       = byte_q;
    assign bus.byte_valid_o = valid_q;
    assign bus.fifo_full_o  = full_q;
    assign bus.overflow_o   = ovf_q;
`ifdef OUT_PARITY_EN
    assign bus.parity_o     = parity_q;
`endif
endmodule

// File: tb/tb_pixel_out_serializer.sv
// Bench for pixel_out_serializer: directed steps plus random traffic checked every
// cycle against a queue-based model of the pixel FIFO and the outgoing byte stream.
module tb_pixel_out_serializer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic nreset;

    pixel_out_serializer_if #(.MAX_PIXEL_BITS(24)) bus ();

    pixel_out_serializer #(
        .MAX_PIXEL_BITS(24),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk_i   (clk),
        .nreset_i(nreset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: pixels waiting in the FIFO, and bytes of the pixel being sent (front = on byte_o).
    logic [23:0] m_fifo[$];
    logic [7:0]  m_cur[$];
    bit          m_ovf;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_load(input bit mode);
        logic [23:0] p;
        p = m_fifo.pop_front();
        if (mode) begin
            m_cur.push_back(p[7:0]);
        end else begin
            m_cur.push_back(p[23:16]);
            m_cur.push_back(p[15:8]);
            m_cur.push_back(p[7:0]);
        end
    endfunction

    function automatic void model_step(input bit push, input logic [23:0] pix,
                                       input bit mode, input bit ack);
        bit full_before;
        logic [7:0] b;
        full_before = (m_fifo.size() == DEPTH);
        if (m_cur.size() != 0) begin
            if (ack) begin
                b = m_cur.pop_front();
                $display("tx byte=%02h", b);
                if (m_cur.size() == 0 && m_fifo.size() != 0) model_load(mode);
            end
        end else if (m_fifo.size() != 0) begin
            model_load(mode);
        end
        if (push) begin
            if (full_before) m_ovf = 1'b1;
            else m_fifo.push_back(pix);
        end
    endfunction

    task automatic check_outputs();
        chk("valid", {23'd0, bus.byte_valid_o}, {23'd0, m_cur.size() != 0});
        if (m_cur.size() != 0) begin
            chk("byte", {16'd0, bus.byte_o}, {16'd0, m_cur[0]});
`ifdef OUT_PARITY_EN
            chk("parity", {23'd0, bus.parity_o}, {23'd0, ^m_cur[0]});
`endif
        end
        chk("full", {23'd0, bus.fifo_full_o}, {23'd0, m_fifo.size() == DEPTH});
        chk("overflow", {23'd0, bus.overflow_o}, {23'd0, m_ovf});
    endtask

    task automatic cycle(input bit push, input logic [23:0] pix, input bit mode, input bit ack);
        bus.px_rdy_i    = push;
        bus.in_pixel_i  = pix;
        bus.byte_mode_i = mode;
        bus.byte_ack_i  = ack;
        @(posedge clk);
        model_step(push, pix, mode, ack);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input bit mode, input bit ack);
        for (int i = 0; i < n; i++) cycle(1'b0, 24'h0, mode, ack);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_byte"}, {16'd0, bus.byte_o}, 24'h0);
        chk({tag, "_valid"}, {23'd0, bus.byte_valid_o}, 24'h0);
        chk({tag, "_full"}, {23'd0, bus.fifo_full_o}, 24'h0);
        chk({tag, "_overflow"}, {23'd0, bus.overflow_o}, 24'h0);
`ifdef OUT_PARITY_EN
        chk({tag, "_parity"}, {23'd0, bus.parity_o}, 24'h0);
`endif
    endtask

    initial begin
        nreset          = 1'b0;
        bus.px_rdy_i    = 1'b0;
        bus.in_pixel_i  = 24'h0;
        bus.byte_mode_i = 1'b0;
        bus.byte_ack_i  = 1'b0;
        m_ovf           = 1'b0;
        #3;
        chk_all_zero("reset");
        @(posedge clk);
        #1 nreset = 1'b1;

        // Single 3-byte pixel, ack held high.
        cycle(1'b1, 24'h123456, 1'b0, 1'b1);
        idle(5, 1'b0, 1'b1);

        // Byte mode, two pixels back-to-back.
        cycle(1'b1, 24'hAABBCC, 1'b1, 1'b1);
        cycle(1'b1, 24'h00007F, 1'b1, 1'b1);
        idle(4, 1'b1, 1'b1);

        // Parity-interesting low bytes.
        cycle(1'b1, 24'h000007, 1'b1, 1'b1);
        cycle(1'b1, 24'h000003, 1'b1, 1'b1);
        idle(4, 1'b1, 1'b1);

        // Stall with ack low, then single-cycle ack pulses.
        cycle(1'b1, 24'h123456, 1'b0, 1'b0);
        idle(5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 24'h0, 1'b0, 1'b1);
            cycle(1'b0, 24'h0, 1'b0, 1'b0);
        end
        idle(2, 1'b0, 1'b1);

        // Fill past capacity with the reader stalled, then drain.
        for (int i = 0; i < 6; i++) cycle(1'b1, 24'h100000 * (i + 1) + 24'h0A0B, 1'b0, 1'b0);
        idle(3, 1'b0, 1'b0);
        idle(20, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a pixel with two more queued.
        cycle(1'b1, 24'hA1A2A3, 1'b0, 1'b0);
        cycle(1'b1, 24'hB1B2B3, 1'b0, 1'b0);
        cycle(1'b1, 24'hC1C2C3, 1'b0, 1'b1);
        nreset = 1'b0;
        #2;
        chk_all_zero("async_reset");
        m_fifo.delete();
        m_cur.delete();
        m_ovf = 1'b0;
        #2 nreset = 1'b1;
        idle(6, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 1) == 1, 24'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 7);
        end
        idle(30, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
